apb_master_bridge: RTL and testbench

- APB initiator: converts a simple valid/ready command interface into APB3 read/write transfers on one slave segment.
- Used by bench and SoC subsystems to drive APB slaves, including the APB slave model and protocol checker.
- Produces one response per accepted command, carrying read data and an error flag.

---
 rtl/apb_master_pkg.sv | 18 +
 rtl/apb_master_wdog.sv | 42 ++++
 rtl/apb_master_bridge.sv | 117 +++++++++++
 tb/tb_apb_master_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// ============================================================================
// Module  : apb_master_pkg
// Brief   : Shared state encoding and wait-counter width for the APB master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg;

    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_SETUP  = 2'b01;
    localparam logic [1:0] c_ACCESS = 2'b10;

    localparam int c_TCNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/apb_master_wdog.sv
// ============================================================================
// Module  : apb_master_wdog
// Brief   : ACCESS-phase wait counter; expires on the LIMIT-th stalled cycle.
//           Built only when APB_MASTER_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef APB_MASTER_TIMEOUT_EN
module apb_master_wdog
    import apb_master_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [c_TCNT_W-1:0] c_LAST = c_TCNT_W'(LIMIT - 1);

    logic [c_TCNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Only a stalled cycle can expire; a ready slave always wins.
    assign o_expire = i_en && (r_count == c_LAST);

endmodule
`endif

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module  : apb_master_bridge
// Brief   : valid/ready command to APB3 initiator, one response per command.
//           Optional ACCESS timeout enabled by macro APB_MASTER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY
);

    logic [1:0] r_state;
    logic       w_expire;

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("apb_master_bridge: TIMEOUT must be within 2..65535");
    end

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_clr    (r_state == c_SETUP),
        .i_en     ((r_state == c_ACCESS) && !PREADY),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= c_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        r_state   <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= c_ACCESS;
                end
                c_ACCESS: begin
                    // PREADY is checked first so a late-ready slave beats the timeout.
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= 1'b0;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= c_IDLE;
                    end else if (w_expire) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// Module  : tb_apb_master_bridge
// Brief   : Self-checking bench for apb_master_bridge with an APB memory slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

    localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    int errors = 0;
    int checks = 0;

    apb_master_bridge #(
        .AWIDTH  (8),
        .DWIDTH  (8),
        .TIMEOUT (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // APB memory slave: inserts s_waits stalled ACCESS cycles per transfer.
    logic [7:0] smem [256];
    int         s_cnt = 0;
    int         s_waits = 0;

    assign PREADY = PSEL && PENABLE && (s_cnt == s_waits);
    assign PRDATA = smem[PADDR];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) s_cnt <= s_cnt + 1;
        else                            s_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
    end

    // Reference model: the contents the slave should hold after completed writes.
    logic [7:0] mem_m [256];

    // One complete transfer from IDLE, checked cycle by cycle against the
    // protocol timeline: SETUP, waits+1 ACCESS cycles (or TMO when it times out), response.
    task automatic run_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input int waits);
        bit         tmo;
        int         lat;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic [3:0] exp_ctl;
        tmo     = TMO_EN && (waits >= TMO);
        lat     = tmo ? TMO + 2 : waits + 3;
        exp_err = tmo;
        exp_rd  = (tmo || wr) ? 8'h00 : mem_m[addr];
        if (!tmo && wr) mem_m[addr] = wdata;
        s_waits   = waits;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL xfer_ready_idle: cmd_ready=%b want 1", cmd_ready);
        end
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        for (int c = 1; c <= lat; c++) begin
            exp_ctl = (c == lat) ? 4'b0011 : ((c == 1) ? 4'b1000 : 4'b1100);
            checks++;
            if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== exp_ctl) begin
                errors++;
                $display("FAIL xfer_ctl cycle %0d: {sel,en,rdy,rsp}=%b want %b",
                         c, {PSEL, PENABLE, cmd_ready, rsp_valid}, exp_ctl);
            end
            checks++;
            if (c < lat) begin
                if ({PADDR, PWRITE} !== {addr, wr} || (wr && PWDATA !== wdata)) begin
                    errors++;
                    $display("FAIL xfer_apb_hold cycle %0d: addr=%h wr=%b wdata=%h want %h %b %h",
                             c, PADDR, PWRITE, PWDATA, addr, wr, wdata);
                end
            end else begin
                if ({rsp_rdata, rsp_err} !== {exp_rd, exp_err}) begin
                    errors++;
                    $display("FAIL xfer_rsp: rdata=%h err=%b want %h %b",
                             rsp_rdata, rsp_err, exp_rd, exp_err);
                end
            end
            @(posedge PCLK); #1;
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL xfer_rsp_pulse: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: sel=%b en=%b wr=%b addr=%h wd=%h rv=%b rd=%h err=%b want all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err);
        end
        #2 PRESET = 1'b0;
        @(posedge PCLK); #1;
        checks++;
        if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: rdy=%b sel=%b rv=%b want 1 0 0", cmd_ready, PSEL, rsp_valid);
        end
    endtask

    task automatic test_zero_wait();
        run_xfer(1'b1, 8'h12, 8'hA5, 0);
    endtask

    task automatic test_readback();
        run_xfer(1'b0, 8'h12, 8'h00, 0);
    endtask

    task automatic test_wait_states();
        run_xfer(1'b1, 8'h34, 8'h3C, 3);
        run_xfer(1'b0, 8'h34, 8'h00, 2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd [4];
        int         idx;
        bit         rdy;
        bit         exp_rsp;
        for (int i = 0; i < 4; i++) begin
            wd[i] = 8'($urandom);
            mem_m[i] = wd[i];
        end
        s_waits   = 0;
        idx       = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'd0;
        cmd_wdata = wd[0];
        for (int c = 1; c <= 12; c++) begin
            rdy = cmd_ready;
            @(posedge PCLK); #1;
            if (rdy && cmd_valid) begin
                idx++;
                if (idx < 4) begin
                    cmd_addr  = 8'(idx);
                    cmd_wdata = wd[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            exp_rsp = (c % 3 == 0);
            checks++;
            if ({PSEL, rsp_valid, cmd_ready} !== {~exp_rsp, exp_rsp, exp_rsp}) begin
                errors++;
                $display("FAIL b2b_cycle %0d: sel=%b rv=%b rdy=%b want %b %b %b",
                         c, PSEL, rsp_valid, cmd_ready, ~exp_rsp, exp_rsp, exp_rsp);
            end
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL b2b_accepts: accepted=%0d want 4", idx);
        end
        for (int i = 0; i < 4; i++) run_xfer(1'b0, 8'(i), 8'h00, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_xfer(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
                     int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_reset_mid_access();
        s_waits   = 1000;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h05;
        cmd_wdata = ~mem_m[5];
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_in_access: sel=%b en=%b want 1 1", PSEL, PENABLE);
        end
        #2 PRESET = 1'b1;
        #1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_async: sel=%b en=%b rv=%b want 0 0 0", PSEL, PENABLE, rsp_valid);
        end
        @(posedge PCLK); #3;
        PRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge PCLK); #1;
            checks++;
            if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
                errors++;
                $display("FAIL midrst_after: rdy=%b sel=%b rv=%b want 1 0 0", cmd_ready, PSEL, rsp_valid);
            end
        end
        run_xfer(1'b0, 8'h05, 8'h00, 0);
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        run_xfer(1'b1, 8'h77, 8'hEE, 1000);
        run_xfer(1'b0, 8'h77, 8'h00, 0);
`else
        int rsp_seen;
        rsp_seen  = 0;
        s_waits   = 1000;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h77;
        cmd_wdata = 8'hEE;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge PCLK); #1;
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0 || {PSEL, PENABLE, rsp_err} !== 3'b110) begin
            errors++;
            $display("FAIL no_timeout_wait: rsp=%0d sel=%b en=%b err=%b want 0 1 1 0",
                     rsp_seen, PSEL, PENABLE, rsp_err);
        end
        #2 PRESET = 1'b1;
        @(posedge PCLK); #3;
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        run_xfer(1'b0, 8'h77, 8'h00, 0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i]  = 8'(i) ^ 8'h5A;
            mem_m[i] = 8'(i) ^ 8'h5A;
        end
        test_reset();
        test_zero_wait();
        test_readback();
        test_wait_states();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
